// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed N-digit 7-segment scan controller.
// Blanking gap between digits; updates are double-buffered and committed at
// frame boundaries (or immediately while disabled) so frames never tear.
// Optional feature macro: DISP_BLINK_EN (per-digit blink on a frame-count phase).
module display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned MAX_STATE    = 5,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [4*NUM_DIGITS-1:0]   upd_states,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic [3:0]                display_state,
  output logic                      frame_tick
);

  localparam int unsigned CNT_MAX    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DWELL_LAST = DWELL_CYCLES - 1;
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
  localparam int unsigned DIGIT_LAST = NUM_DIGITS - 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]     active_q, active_d;
  logic [NUM_DIGITS-1:0][3:0]     shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][3:0]     clamped_c;
  logic                           pending_q, pending_d;
  logic                           boundary_c;
  logic                           phase_d;
  logic                           blink_off_c;

  logic [NUM_DIGITS-1:0]          anode_d;
  logic [3:0]                     display_state_d;
  logic                           frame_tick_d;
  logic                           upd_ready_d;

  // Clamp incoming digit values the cathode decoder cannot show to 0.
  always_comb begin
    clamped_c = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      clamped_c[i] = (upd_states[4*i +: 4] > 4'(MAX_STATE)) ? 4'd0 : upd_states[4*i +: 4];
    end
  end

  // Scan FSM next state, digit index, and double-buffered digit contents.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    active_d   = active_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    boundary_c = 1'b0;

    if (!en) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (BLANK_CYCLES == 0 || cnt_q == CW'(BLANK_LAST)) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CW'(DWELL_LAST)) begin
            cnt_d   = '0;
            state_d = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
            if (idx_q == IW'(DIGIT_LAST)) begin
              idx_d      = '0;
              boundary_c = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_BLANK;
      endcase

      if (boundary_c && pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    // Accept only while nothing is pending, so a capture never overlaps a commit.
    if (upd_valid && !pending_q) begin
      shadow_d  = clamped_c;
      pending_d = 1'b1;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q;

  // Blink phase toggles after every BLINK_FRAMES frame boundaries.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (boundary_c) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  logic blink_unused;
  assign phase_d      = 1'b0;
  assign blink_unused = ^blink_mask;
`endif

  // Output values for the state being entered on this edge.
  always_comb begin
    anode_d     = '1;
    blink_off_c = 1'b0;
`ifdef DISP_BLINK_EN
    blink_off_c = phase_d & blink_mask[idx_d];
`endif
    if (state_d == ST_DRIVE && !blink_off_c) begin
      anode_d[idx_d] = 1'b0;
    end
    display_state_d = active_d[idx_d];
    frame_tick_d    = boundary_c;
    upd_ready_d     = ~pending_d;
  end

  // State, data and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      anode         <= '1;
      display_state <= 4'd0;
      frame_tick    <= 1'b0;
      upd_ready     <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      anode         <= anode_d;
      display_state <= display_state_d;
      frame_tick    <= frame_tick_d;
      upd_ready     <= upd_ready_d;
    end
  end

endmodule
